reg_bank_sb: RTL and testbench

- 16-entry general-purpose register bank with a per-register busy scoreboard and a sequential bulk-clear engine.
- Directly upstream of the 16:1 register-select multiplexers: regs_flat slices feed their in1..in16 inputs, and register i drives in(i+1).
- Sequences write-back, tracks outstanding destination reservations for issue-stall logic, and supports a multi-cycle clear of the whole bank.

---
 rtl/reg_bank_sb_pkg.sv | 14 +
 rtl/reg_bank_sb_busy_scoreboard.sv | 36 +++
 rtl/reg_bank_sb.sv | 92 +++++++++
 tb/tb_reg_bank_sb.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_sb_pkg.sv
// reg_bank_sb shared definitions.
// Bank geometry, FSM encoding and slice width.
package reg_bank_sb_pkg;

  localparam int NREGS   = 16;
  localparam int ADDR_W  = 4;
  localparam int SLICE_W = 32;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } state_t;

endpackage

// File: rtl/reg_bank_sb_busy_scoreboard.sv
// Per-register pending-write flags.
// Set wins over write/sweep clear; r0 exempt when ZERO_R0.
module busy_scoreboard
  import reg_bank_sb_pkg::*;
#(
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rsv_fire,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              sweep,
  input  logic [ADDR_W-1:0] sweep_addr,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] nxt;

  // Clears first, then the reservation set so it wins.
  always_comb begin
    nxt = busy;
    if (wr_fire)  nxt[wr_addr]    = 1'b0;
    if (sweep)    nxt[sweep_addr] = 1'b0;
    if (rsv_fire) nxt[rsv_addr]   = 1'b1;
    if (ZERO_R0)  nxt[0]          = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= nxt;
  end

endmodule

// File: rtl/reg_bank_sb.sv
// 16-entry register bank with busy scoreboard.
// Multi-cycle bulk clear sweeps one register per cycle.
module reg_bank_sb
  import reg_bank_sb_pkg::*;
#(
  parameter int n       = SLICE_W,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [n-1:0]         wr_data,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic                 rsv_ok,
  input  logic                 clr_req,
  output logic                 clr_done,
  output logic [NREGS-1:0]     busy,
  output logic [NREGS*n-1:0]   regs_flat
);

  logic [n-1:0]      regs [NREGS];
  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              idle;
  logic              wr_fire;
  logic              rsv_fire;
  logic              wr_keep;
  logic              sweep;
  logic              r0_hit;

  assign idle     = (state == IDLE);
  assign wr_ready = idle;
  assign r0_hit   = ZERO_R0 && (rsv_addr == '0);
  assign rsv_ok   = idle && (r0_hit || !busy[rsv_addr]);
  assign wr_fire  = wr_valid && wr_ready;
  assign rsv_fire = rsv_en && rsv_ok;
  assign wr_keep  = wr_fire && !(ZERO_R0 && wr_addr == '0);
  assign sweep    = (state == CLEARING);

  busy_scoreboard #(
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .wr_fire    (wr_fire),
    .wr_addr    (wr_addr),
    .rsv_fire   (rsv_fire),
    .rsv_addr   (rsv_addr),
    .sweep      (sweep),
    .sweep_addr (clr_ptr),
    .busy       (busy)
  );

  // Data array, clear FSM and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      state    <= IDLE;
      clr_ptr  <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_keep) regs[wr_addr] <= wr_data;
          if (clr_req) begin
            state   <= CLEARING;
            clr_ptr <= '0;
          end
        end
        CLEARING: begin
          regs[clr_ptr] <= '0;
          if (clr_ptr == ADDR_W'(NREGS - 1)) begin
            state    <= IDLE;
            clr_done <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*n +: n] = regs[g];
  end

endmodule

// File: tb/tb_reg_bank_sb.sv
// Scoreboard bench for reg_bank_sb.
// Abstract model predicts each cycle; monitor compares.
module tb_reg_bank_sb;
  import reg_bank_sb_pkg::*;

  logic         clk = 1'b0;
  logic         reset, wr_valid, rsv_en, clr_req;
  logic [3:0]   wr_addr, rsv_addr;
  logic [31:0]  wr_data;
  logic         wr_ready, rsv_ok, clr_done;
  logic [15:0]  busy;
  logic [511:0] regs_flat;

  logic         z_reset, z_wr_valid, z_rsv_en, z_clr_req;
  logic [3:0]   z_wr_addr, z_rsv_addr;
  logic [31:0]  z_wr_data;
  logic         z_wr_ready, z_rsv_ok, z_clr_done;
  logic [15:0]  z_busy;
  logic [511:0] z_regs_flat;

  always #5 clk = ~clk;

  reg_bank_sb #(.n(32), .ZERO_R0(1'b0)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .clr_req(clr_req), .clr_done(clr_done),
    .busy(busy), .regs_flat(regs_flat)
  );

  reg_bank_sb #(.n(32), .ZERO_R0(1'b1)) dut_z (
    .clk(clk), .reset(z_reset),
    .wr_valid(z_wr_valid), .wr_ready(z_wr_ready),
    .wr_addr(z_wr_addr), .wr_data(z_wr_data),
    .rsv_en(z_rsv_en), .rsv_addr(z_rsv_addr), .rsv_ok(z_rsv_ok),
    .clr_req(z_clr_req), .clr_done(z_clr_done),
    .busy(z_busy), .regs_flat(z_regs_flat)
  );

  typedef struct {
    logic         wr_ready;
    logic         rsv_ok;
    logic         clr_done;
    logic [15:0]  busy;
    logic [511:0] regs;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] m_reg [16];
  bit          m_busy [16];
  int          m_left = 0;
  bit          m_done = 0;
  bit          known  = 0;

  task automatic chk(input string nm, input logic [511:0] a,
                     input logic [511:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
    end
  endtask

  function automatic logic [511:0] m_flat();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = m_reg[i];
    return f;
  endfunction

  function automatic logic [15:0] m_bvec();
    logic [15:0] b;
    for (int i = 0; i < 16; i++) b[i] = m_busy[i];
    return b;
  endfunction

  task automatic cyc(input bit r, input bit wv, input logic [3:0] wa,
                     input logic [31:0] wd, input bit re,
                     input logic [3:0] ra, input bit cr);
    exp_t e;
    bit   idle, grant;
    int   idx;
    reset = r; wr_valid = wv; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra; clr_req = cr;
    idle = (m_left == 0);
    if (known) begin
      e.wr_ready = idle;
      e.rsv_ok   = idle && !m_busy[ra];
      e.clr_done = m_done;
      e.busy     = m_bvec();
      e.regs     = m_flat();
      q.push_back(e);
    end
    if (r) begin
      for (int i = 0; i < 16; i++) begin
        m_reg[i] = '0; m_busy[i] = 0;
      end
      m_left = 0; m_done = 0; known = 1;
    end else if (idle) begin
      m_done = 0;
      grant = re && !m_busy[ra];
      if (wv) begin m_reg[wa] = wd; m_busy[wa] = 0; end
      if (grant) m_busy[ra] = 1;
      if (cr) m_left = 16;
    end else begin
      idx = 16 - m_left;
      m_reg[idx] = '0; m_busy[idx] = 0;
      m_left--;
      m_done = (m_left == 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    cyc(0, 0, 4'd0, 32'd0, 0, 4'd0, 0);
  endtask

  // Monitor: compare the DUT against the oldest prediction each cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("wr_ready", wr_ready, e.wr_ready);
      chk("rsv_ok", rsv_ok, e.rsv_ok);
      chk("clr_done", clr_done, e.clr_done);
      chk("busy", busy, e.busy);
      chk("regs_flat", regs_flat, e.regs);
    end
  end

  initial begin
    z_reset = 1; z_wr_valid = 0; z_wr_addr = 0; z_wr_data = 0;
    z_rsv_en = 0; z_rsv_addr = 0; z_clr_req = 0;

    cyc(1, 0, 4'd0, 32'd0, 0, 4'd0, 0);
    cyc(1, 0, 4'd0, 32'd0, 0, 4'd0, 0);

    cyc(0, 1, 4'd5, 32'hDEADBEEF, 0, 4'd0, 0);
    nop();

    cyc(0, 0, 4'd0, 32'd0, 1, 4'd7, 0);
    cyc(0, 0, 4'd0, 32'd0, 1, 4'd7, 0);
    cyc(0, 1, 4'd7, 32'h12, 0, 4'd0, 0);
    nop();

    cyc(0, 1, 4'd3, 32'hA, 1, 4'd3, 0);
    cyc(0, 1, 4'd3, 32'hB, 1, 4'd3, 0);
    nop();

    for (int i = 0; i < 16; i++)
      cyc(0, 1, 4'(i), 32'h100 + i, (i % 3) == 0, 4'((i + 5) % 16), 0);
    cyc(0, 1, 4'd2, 32'h55, 0, 4'd0, 1);
    for (int i = 0; i < 16; i++)
      cyc(0, 1, 4'd9, 32'h77, 1, 4'd4, 1);
    cyc(0, 1, 4'd9, 32'h77, 0, 4'd0, 0);
    nop();
    nop();

    for (int i = 0; i < 4; i++)
      cyc(0, 1, 4'(i + 8), 32'hC0 + i, 1, 4'(i), 0);
    cyc(0, 0, 4'd0, 32'd0, 0, 4'd0, 1);
    for (int i = 0; i < 5; i++) nop();
    cyc(1, 0, 4'd0, 32'd0, 0, 4'd0, 0);
    for (int i = 0; i < 20; i++) nop();

    for (int i = 0; i < 600; i++)
      cyc(($urandom % 150) == 0, $urandom_range(1, 0),
          4'($urandom_range(15, 0)), $urandom,
          $urandom_range(1, 0), 4'($urandom_range(15, 0)),
          ($urandom % 50) == 0);
    for (int i = 0; i < 18; i++) nop();

    @(negedge clk);
    chk("queue_drained", 512'(q.size()), 512'd0);

    @(posedge clk); #1;
    z_reset = 0;
    z_wr_valid = 1; z_wr_addr = 4'd0; z_wr_data = 32'hFFFF_FFFF;
    z_rsv_en = 1; z_rsv_addr = 4'd0;
    @(negedge clk);
    chk("z_wr_ready", z_wr_ready, 1'b1);
    chk("z_rsv_ok_r0", z_rsv_ok, 1'b1);
    @(posedge clk); #1;
    z_wr_valid = 1; z_wr_addr = 4'd1; z_wr_data = 32'h1234;
    z_rsv_en = 1; z_rsv_addr = 4'd2;
    @(negedge clk);
    chk("z_r0_data", z_regs_flat[31:0], 32'd0);
    chk("z_busy_r0", z_busy, 16'h0000);
    @(posedge clk); #1;
    z_wr_valid = 0; z_rsv_en = 1; z_rsv_addr = 4'd0;
    @(negedge clk);
    chk("z_r1_data", z_regs_flat[63:32], 32'h1234);
    chk("z_busy_r2", z_busy, 16'h0004);
    chk("z_rsv_ok_r0_again", z_rsv_ok, 1'b1);
    @(posedge clk); #1;
    z_rsv_en = 0;
    @(negedge clk);
    chk("z_busy_final", z_busy, 16'h0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
